// File: rtl/wb_timeout_defs_pkg.sv
// Shared definitions for the wishbone timeout guard: FSM encoding and
// the constant values driven on a forced error and at count saturation.
package wb_timeout_defs;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } wb_state_e;

  localparam logic [31:0] WB_TIMEOUT_ERROR_DATA = 32'hFFFF_FFFF;
  localparam logic [7:0]  TIMEOUT_COUNT_MAX     = 8'hFF;

endpackage

// File: rtl/wb_saturating_counter.sv
// Up-counter that sticks at MAX. An increment in the same cycle as a clear
// restarts the count at 1 so the coincident event is not lost.
module wb_saturating_counter #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] cnt_d, cnt_q;

  // Next count: clear, then increment with saturation.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) cnt_d = '0;
    if (inc) begin
      if (clr)               cnt_d = WIDTH'(1);
      else if (cnt_q != MAX) cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/wb_timeout_guard.sv
// Wishbone response guard: registers one upstream request, replays it on the
// Caravel bus and forces an error response if nothing answers in time.
// Optional statistics block is built only when WB_TIMEOUT_STATS_EN is defined.
module wb_timeout_guard
  import wb_timeout_defs::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMER_WIDTH    = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        upstream_wb_cyc_i,
  input  logic        upstream_wb_stb_i,
  input  logic        upstream_wb_we_i,
  input  logic [3:0]  upstream_wb_sel_i,
  input  logic [31:0] upstream_wb_data_i,
  input  logic [27:0] upstream_wb_adr_i,
  output logic        upstream_wb_ack_o,
  output logic        upstream_wb_error_o,
  output logic        upstream_wb_stall_o,
  output logic [31:0] upstream_wb_data_o,
  output logic        caravel_wb_cyc_o,
  output logic        caravel_wb_stb_o,
  output logic        caravel_wb_we_o,
  output logic [3:0]  caravel_wb_sel_o,
  output logic [31:0] caravel_wb_data_o,
  output logic [27:0] caravel_wb_adr_o,
  input  logic        caravel_wb_ack_i,
  input  logic        caravel_wb_stall_i,
  input  logic        caravel_wb_error_i,
  input  logic [31:0] caravel_wb_data_i,
  input  logic        clear_status,
  output logic        timeout_flag,
  output logic [7:0]  timeout_count,
  output logic [27:0] timeout_address
);

  // Timer value on the last cycle the bus is held before forcing an error.
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  wb_state_e              state_d, state_q;
  logic [TIMER_WIDTH-1:0] timer_d, timer_q;
  logic                   hold_we_d, hold_we_q;
  logic [3:0]             hold_sel_d, hold_sel_q;
  logic [31:0]            hold_data_d, hold_data_q;
  logic [27:0]            hold_adr_d, hold_adr_q;
  logic                   resp_err_d, resp_err_q;
  logic [31:0]            resp_data_d, resp_data_q;
  logic                   timeout_evt;
  logic                   bus_active;

  assign bus_active = (state_q == REQUEST) || (state_q == WAIT);

  // Next-state, timer and capture logic. Abort beats any response;
  // error beats ack; a response beats timer expiry.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    hold_we_d   = hold_we_q;
    hold_sel_d  = hold_sel_q;
    hold_data_d = hold_data_q;
    hold_adr_d  = hold_adr_q;
    resp_err_d  = resp_err_q;
    resp_data_d = resp_data_q;
    timeout_evt = 1'b0;
    case (state_q)
      IDLE: begin
        resp_err_d  = 1'b0;
        resp_data_d = '0;
        if (upstream_wb_cyc_i && upstream_wb_stb_i) begin
          hold_we_d   = upstream_wb_we_i;
          hold_sel_d  = upstream_wb_sel_i;
          hold_data_d = upstream_wb_data_i;
          hold_adr_d  = upstream_wb_adr_i;
          timer_d     = '0;
          state_d     = REQUEST;
        end
      end
      REQUEST, WAIT: begin
        timer_d = timer_q + TIMER_WIDTH'(1);
        if (!upstream_wb_cyc_i) begin
          state_d = IDLE;
        end else if (caravel_wb_ack_i || caravel_wb_error_i) begin
          state_d     = RESPOND;
          resp_err_d  = caravel_wb_error_i;
          resp_data_d = (!caravel_wb_error_i && !hold_we_q) ? caravel_wb_data_i : '0;
        end else if (timer_q == TIMER_LAST) begin
          state_d     = RESPOND;
          resp_err_d  = 1'b1;
          resp_data_d = WB_TIMEOUT_ERROR_DATA;
          timeout_evt = 1'b1;
        end else if (state_q == REQUEST && !caravel_wb_stall_i) begin
          state_d = WAIT;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM, timer, hold and response registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      hold_we_q   <= 1'b0;
      hold_sel_q  <= '0;
      hold_data_q <= '0;
      hold_adr_q  <= '0;
      resp_err_q  <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      hold_we_q   <= hold_we_d;
      hold_sel_q  <= hold_sel_d;
      hold_data_q <= hold_data_d;
      hold_adr_q  <= hold_adr_d;
      resp_err_q  <= resp_err_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Downstream fields are zeroed whenever cyc is low.
  assign caravel_wb_cyc_o  = bus_active;
  assign caravel_wb_stb_o  = (state_q == REQUEST);
  assign caravel_wb_we_o   = bus_active & hold_we_q;
  assign caravel_wb_sel_o  = bus_active ? hold_sel_q  : '0;
  assign caravel_wb_data_o = bus_active ? hold_data_q : '0;
  assign caravel_wb_adr_o  = bus_active ? hold_adr_q  : '0;

  assign upstream_wb_stall_o = (state_q != IDLE);
  assign upstream_wb_ack_o   = (state_q == RESPOND) && !resp_err_q;
  assign upstream_wb_error_o = (state_q == RESPOND) &&  resp_err_q;
  assign upstream_wb_data_o  = (state_q == RESPOND) ? resp_data_q : '0;

`ifdef WB_TIMEOUT_STATS_EN
  logic        flag_d, flag_q;
  logic [27:0] addr_d, addr_q;

  // Sticky flag and last address; a timeout overrides a coincident clear.
  always_comb begin
    flag_d = flag_q;
    addr_d = addr_q;
    if (clear_status) begin
      flag_d = 1'b0;
      addr_d = '0;
    end
    if (timeout_evt) begin
      flag_d = 1'b1;
      addr_d = hold_adr_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      flag_q <= 1'b0;
      addr_q <= '0;
    end else begin
      flag_q <= flag_d;
      addr_q <= addr_d;
    end
  end

  wb_saturating_counter #(
    .WIDTH (8),
    .MAX   (TIMEOUT_COUNT_MAX)
  ) u_timeout_cnt (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .clr   (clear_status),
    .inc   (timeout_evt),
    .count (timeout_count)
  );

  assign timeout_flag    = flag_q;
  assign timeout_address = addr_q;
`else
  logic unused_stats;
  assign unused_stats    = clear_status ^ timeout_evt;
  assign timeout_flag    = 1'b0;
  assign timeout_count   = '0;
  assign timeout_address = '0;
`endif

endmodule

// File: tb/tb_wb_timeout_guard.sv
// Scoreboard bench for wb_timeout_guard (TIMEOUT_CYCLES=8). Expected
// responses are queued as requests are issued and popped by a monitor.
module tb_wb_timeout_guard;

`ifdef WB_TIMEOUT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        u_cyc, u_stb, u_we;
  logic [3:0]  u_sel;
  logic [31:0] u_data;
  logic [27:0] u_adr;
  logic        u_ack, u_err, u_stall;
  logic [31:0] u_rdata;
  logic        c_cyc, c_stb, c_we;
  logic [3:0]  c_sel;
  logic [31:0] c_wdata;
  logic [27:0] c_adr;
  logic        c_ack, c_stall, c_err;
  logic [31:0] c_rdata;
  logic        clr;
  logic        t_flag;
  logic [7:0]  t_count;
  logic [27:0] t_addr;

  int   n_tests = 0;
  int   n_fail  = 0;
  rsp_t sb[$];

  wb_timeout_guard #(.TIMEOUT_CYCLES(8), .TIMER_WIDTH(16)) dut (
    .wb_clk_i            (clk),
    .wb_rst_i            (rst),
    .upstream_wb_cyc_i   (u_cyc),
    .upstream_wb_stb_i   (u_stb),
    .upstream_wb_we_i    (u_we),
    .upstream_wb_sel_i   (u_sel),
    .upstream_wb_data_i  (u_data),
    .upstream_wb_adr_i   (u_adr),
    .upstream_wb_ack_o   (u_ack),
    .upstream_wb_error_o (u_err),
    .upstream_wb_stall_o (u_stall),
    .upstream_wb_data_o  (u_rdata),
    .caravel_wb_cyc_o    (c_cyc),
    .caravel_wb_stb_o    (c_stb),
    .caravel_wb_we_o     (c_we),
    .caravel_wb_sel_o    (c_sel),
    .caravel_wb_data_o   (c_wdata),
    .caravel_wb_adr_o    (c_adr),
    .caravel_wb_ack_i    (c_ack),
    .caravel_wb_stall_i  (c_stall),
    .caravel_wb_error_i  (c_err),
    .caravel_wb_data_i   (c_rdata),
    .clear_status        (clr),
    .timeout_flag        (t_flag),
    .timeout_count       (t_count),
    .timeout_address     (t_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request strobe; returns in the first REQUEST cycle with cyc held.
  task automatic req(input logic we, input logic [27:0] adr, input logic [31:0] data);
    u_cyc = 1'b1; u_stb = 1'b1; u_we = we; u_adr = adr; u_data = data; u_sel = 4'hF;
    tick();
    u_stb = 1'b0;
  endtask

  task automatic chk_stats(input string tag, input logic f, input logic [7:0] c, input logic [27:0] a);
    chk({tag, "_flag"},  t_flag,  STATS ? f : 1'b0);
    chk({tag, "_count"}, t_count, STATS ? c : 8'h0);
    chk({tag, "_addr"},  t_addr,  STATS ? a : 28'h0);
  endtask

  // Response monitor: every upstream ack/error must match the queue head.
  always @(negedge clk) begin
    if (u_ack || u_err) begin
      chk("ack_err_excl", u_ack & u_err, 1'b0);
      if (sb.size() == 0) begin
        chk("unexpected_resp", 1'b1, 1'b0);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        chk("resp_err",  u_err,   e.err);
        chk("resp_data", u_rdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cnt;
    rst = 1'b1; u_cyc = 0; u_stb = 0; u_we = 0; u_sel = 0; u_data = 0; u_adr = 0;
    c_ack = 0; c_stall = 0; c_err = 0; c_rdata = 0; clr = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_ccyc",  c_cyc,   1'b0);
    chk("rst_stall", u_stall, 1'b0);
    chk("rst_ack",   u_ack,   1'b0);
    chk("rst_rdata", u_rdata, 32'h0);
    chk("rst_cadr",  c_adr,   28'h0);
    chk_stats("rst", 1'b0, 8'h0, 28'h0);

    // Zero-wait write.
    sb.push_back('{err: 1'b0, data: 32'h0});
    req(1'b1, 28'h0000010, 32'hDEADBEEF);
    chk("wr_cyc",   c_cyc,   1'b1);
    chk("wr_stb",   c_stb,   1'b1);
    chk("wr_we",    c_we,    1'b1);
    chk("wr_adr",   c_adr,   28'h0000010);
    chk("wr_data",  c_wdata, 32'hDEADBEEF);
    chk("wr_sel",   c_sel,   4'hF);
    chk("wr_stall", u_stall, 1'b1);
    tick();
    chk("wr_wait_stb", c_stb, 1'b0);
    chk("wr_wait_ack", u_ack, 1'b0);
    c_ack = 1'b1;
    tick();
    c_ack = 1'b0; u_cyc = 1'b0;
    chk("wr_ack_3cyc", u_ack, 1'b1);
    chk("wr_no_err",   u_err, 1'b0);
    tick();
    chk("wr_ack_once", u_ack, 1'b0);

    // Read with three stall cycles.
    c_stall = 1'b1;
    sb.push_back('{err: 1'b0, data: 32'h12345678});
    req(1'b0, 28'h0000020, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("rd_stb_held", c_stb, 1'b1);
      if (i == 3) c_stall = 1'b0;
      tick();
    end
    chk("rd_stb_drop", c_stb, 1'b0);
    c_ack = 1'b1; c_rdata = 32'h12345678;
    tick();
    c_ack = 1'b0; c_rdata = 32'h0; u_cyc = 1'b0;
    chk("rd_data", u_rdata, 32'h12345678);
    tick();
    chk("rd_ack_once", u_ack,   1'b0);
    chk("rd_data_clr", u_rdata, 32'h0);

    // Timeout with no response.
    sb.push_back('{err: 1'b1, data: 32'hFFFFFFFF});
    req(1'b0, 28'h0ABCDEF, 32'h0);
    for (int i = 0; i < 8; i++) begin
      chk("to_cyc_held", c_cyc, 1'b1);
      tick();
    end
    chk("to_cyc_drop", c_cyc, 1'b0);
    chk("to_err",      u_err, 1'b1);
    chk_stats("to", 1'b1, 8'd1, 28'h0ABCDEF);
    u_cyc = 1'b0;
    tick();
    chk("to_err_once", u_err, 1'b0);

    // Error and ack together in the REQUEST cycle.
    sb.push_back('{err: 1'b1, data: 32'h0});
    req(1'b0, 28'h0000030, 32'h0);
    c_ack = 1'b1; c_err = 1'b1; c_rdata = 32'hA5A5A5A5;
    tick();
    c_ack = 1'b0; c_err = 1'b0; c_rdata = 32'h0; u_cyc = 1'b0;
    chk("ea_ack", u_ack, 1'b0);
    chk("ea_err", u_err, 1'b1);
    chk_stats("ea", 1'b1, 8'd1, 28'h0ABCDEF);
    tick();

    // Upstream abort in WAIT: no response.
    req(1'b1, 28'h0000040, 32'h55);
    tick();
    u_cyc = 1'b0;
    tick();
    chk("ab_ccyc",  c_cyc,   1'b0);
    chk("ab_stall", u_stall, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("ab_noresp", sb.size(), 0);

    // Reset mid-REQUEST: no response, everything back to 0.
    c_stall = 1'b1;
    req(1'b1, 28'h0000050, 32'h66);
    rst = 1'b1;
    tick();
    chk("rs_ccyc",  c_cyc,   1'b0);
    chk("rs_cstb",  c_stb,   1'b0);
    chk("rs_stall", u_stall, 1'b0);
    chk("rs_cadr",  c_adr,   28'h0);
    chk_stats("rs", 1'b0, 8'h0, 28'h0);
    rst = 1'b0; u_cyc = 1'b0; c_stall = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // 300 timeouts: count saturates.
    exp_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      int n;
      sb.push_back('{err: 1'b1, data: 32'hFFFFFFFF});
      req(1'b0, 28'(k), 32'h0);
      n = 0;
      while (!u_err && n < 20) begin tick(); n++; end
      chk("sat_to_seen", n < 20, 1'b1);
      if (exp_cnt < 255) exp_cnt++;
      u_cyc = 1'b0;
      tick();
    end
    chk_stats("sat", 1'b1, 8'(exp_cnt), 28'd299);

    // clear_status coincident with a timeout.
    sb.push_back('{err: 1'b1, data: 32'hFFFFFFFF});
    req(1'b0, 28'h0123456, 32'h0);
    for (int i = 0; i < 7; i++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_to_err", u_err, 1'b1);
    chk_stats("clr_to", 1'b1, 8'd1, 28'h0123456);
    u_cyc = 1'b0;
    tick();

    // Plain clear.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_stats("clr", 1'b0, 8'h0, 28'h0);

    tick(); tick();
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
